display_reader: RTL
===================

Name: display_reader

Overview:
- Reverse of the 7-segment letter driver: samples a GFEDCBA segment bus, which may be asynchronous.
- Waits until the pattern has been stable for a set number of cycles, then decodes it back to a 5-bit letter index (a=0 … z=25).
- Queues each newly stable letter in a small FIFO with a valid/ready output handshake.
- Used to read back a driven display for self-check, or to capture letters from an external segment source.

Parameters:
- STABLE_CYCLES, 4, consecutive synced cycles a pattern must hold before commit (≥1).
- DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- display  in  7  segment bus, bit6=G … bit0=A, same encoding as the letter driver.
- letter  out  5  FIFO head letter index.
- err  out  1  FIFO head entry came from an undecodable pattern.
- valid  out  1  FIFO head holds an entry.
- ready  in  1  consumer accepts the head this cycle.
- overflow  out  1  one-cycle pulse when a commit is dropped because the FIFO is full.

Behaviour:
- Reset, asynchronous on rst_n low, all cleared immediately:
  - sync regs, cand, last, cnt = 0.
  - FIFO empty; valid=0, letter=0, err=0, overflow=0.
  - Entries queued before reset are lost.
- Synchroniser: two flops, sync1 then sync2. Only sync2 is used downstream.
- Stability tracker, per clk edge:
  - If sync2 != cand: cand<=sync2, cnt<=0.
  - Else if cnt<STABLE_CYCLES: cnt<=cnt+1.
  - The edge where cnt goes STABLE_CYCLES-1 → STABLE_CYCLES is the commit edge.
  - cnt saturates at STABLE_CYCLES. A held pattern commits only once.
- Commit edge, only if cand != last:
  - last<=cand.
  - If cand==7'h00 (blank): nothing is pushed. Blank re-arms repeats: "a" then "a" requires a blank between them.
  - If cand matches a letter pattern: push {err=0, index}.
  - Otherwise, including 7'h40: push {err=1, letter=5'h1F}.
  - If cand==last: no action.
- Decode table, 7'bGFEDCBA → index: a 1110111, b 1111100, c 1011000, d 1011110, e 1111001, f 1110001, g 1101111, h 1110110, i 0000110, j 0011110, k 1111000, l 0111000, m 0010101, n 1010100, o 1011100, p 1110011, q 1100111, r 1010000, s 1101101, t 1000110, u 0111110, v 0011100, w 0101010, x 1001001, y 1101110, z 1011011. Indices run 0..25 in that order.
- Latency: if display changes (setup met) before edge 0, the FIFO write occurs at edge 2+STABLE_CYCLES. valid is high after that edge when the FIFO was empty (default: 7th edge).
- Glitches: a pattern held for fewer than STABLE_CYCLES synced cycles never commits. last is unchanged.
- FIFO behaviour:
  - Transfer happens when valid&&ready at the edge. The head advances.
  - letter/err are held stable while valid&&!ready.
  - letter/err are undefined-but-registered when valid=0; they keep their last value.
- FIFO full:
  - Commit with no simultaneous pop: entry dropped, overflow=1 for exactly one cycle. last still updates.
  - Commit with simultaneous pop: push accepted, no overflow.
- FIFO empty, pop with valid=0: ignored. Pointers wrap modulo DEPTH.
- Reset mid-count: cnt and cand clear. If display holds a letter after reset release, it re-commits after full latency, because last = blank.

Test Plan:
- Reset check: drive rst_n low mid-stream with 2 entries queued → valid=0, overflow=0, letter=0 immediately. After release with display held at 7'b1110111, exactly one entry (letter 0) appears.
- Basic decode and latency: ready=1, display 0→7'b1110110 held for 20 cycles → valid on the 7th edge, letter=7 (h), err=0. Exactly one transfer occurs.
- Glitch rejection: display 7'b0000110 for 3 cycles, then back to 0 → no valid, no overflow. Then hold 7'b0000110 for 6 cycles → letter=8.
- Repeat and separator: sequence a(10 cyc), a(10 cyc, unchanged), blank(10), a(10), z(10) → entries exactly 0, 0, 25. Blank is never emitted.
- Invalid pattern: display=7'h40 held → letter=5'h1F, err=1. Then 7'b1011011 → letter=25, err=0.
- Overflow and backpressure: ready=0; commit b, c, d, e, f each separated by blank → overflow pulses once (on f). Raising ready pops 1, 2, 3, 4 in order, then valid=0. A commit coinciding with a pop while full is accepted with no overflow.

Source files
------------

// File: rtl/display_reader.sv
// display_reader
//   Reads a 7-segment GFEDCBA bus back into 5-bit letter indices (a=0 .. z=25).
//   The bus is synchronised through two flops. A pattern must then hold for
//   STABLE_CYCLES synced cycles before it is committed. Each newly committed
//   non-blank pattern is queued in a DEPTH-entry FIFO. Patterns that do not
//   decode are queued as err=1 with letter=5'h1F.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   display  segment bus, bit6=G .. bit0=A (may be asynchronous to clk)
//   letter   FIFO head letter index (registered, holds its value when valid=0)
//   err      FIFO head came from an undecodable pattern
//   valid    FIFO head holds an entry
//   ready    consumer accepts the head at this edge
//   overflow one-cycle pulse when a commit is dropped because the FIFO is full
module display_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] display,
    output logic [4:0] letter,
    output logic       err,
    output logic       valid,
    input  logic       ready,
    output logic       overflow
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [6:0]    sync1, sync2;
    logic [6:0]    cand, last;
    logic [CW-1:0] cnt;

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] rptr, wptr, rptr_nx;
    logic [AW:0]   count, remain;

    logic          dec_ok;
    logic [4:0]    dec_idx;
    logic          commit, take, push, pop, full, drop;
    logic [5:0]    push_data, head_nx;

    // Letter decode of the stable candidate.
    always_comb begin
        dec_ok  = 1'b1;
        dec_idx = '0;
        case (cand)
            7'b1110111: dec_idx = 5'd0;
            7'b1111100: dec_idx = 5'd1;
            7'b1011000: dec_idx = 5'd2;
            7'b1011110: dec_idx = 5'd3;
            7'b1111001: dec_idx = 5'd4;
            7'b1110001: dec_idx = 5'd5;
            7'b1101111: dec_idx = 5'd6;
            7'b1110110: dec_idx = 5'd7;
            7'b0000110: dec_idx = 5'd8;
            7'b0011110: dec_idx = 5'd9;
            7'b1111000: dec_idx = 5'd10;
            7'b0111000: dec_idx = 5'd11;
            7'b0010101: dec_idx = 5'd12;
            7'b1010100: dec_idx = 5'd13;
            7'b1011100: dec_idx = 5'd14;
            7'b1110011: dec_idx = 5'd15;
            7'b1100111: dec_idx = 5'd16;
            7'b1010000: dec_idx = 5'd17;
            7'b1101101: dec_idx = 5'd18;
            7'b1000110: dec_idx = 5'd19;
            7'b0111110: dec_idx = 5'd20;
            7'b0011100: dec_idx = 5'd21;
            7'b0101010: dec_idx = 5'd22;
            7'b1001001: dec_idx = 5'd23;
            7'b1101110: dec_idx = 5'd24;
            7'b1011011: dec_idx = 5'd25;
            default: begin
                dec_ok  = 1'b0;
                dec_idx = 5'h1F;
            end
        endcase
    end

    assign valid = (count != '0);

    always_comb begin
        full      = (count == FULL_CNT);
        pop       = valid && ready;
        // Commit edge: counter steps from STABLE_CYCLES-1 to STABLE_CYCLES.
        commit    = (sync2 == cand) && (cnt == CNT_LAST);
        take      = commit && (cand != last) && (cand != '0);
        // A full FIFO still accepts a commit when the head leaves on the same edge.
        push      = take && (!full || pop);
        drop      = take && full && !pop;
        push_data = {~dec_ok, dec_idx};
        rptr_nx   = pop ? rptr + AW'(1) : rptr;
        remain    = count - (AW + 1)'(pop);
        // Head is kept in output registers so it holds its last value when empty.
        head_nx   = {err, letter};
        if (remain != '0)
            head_nx = mem[rptr_nx];
        else if (push)
            head_nx = push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            last     <= '0;
            cnt      <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            letter   <= '0;
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sync1 <= display;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (commit && (cand != last))
                last <= cand;
            if (push)
                wptr <= wptr + AW'(1);
            rptr          <= rptr_nx;
            count         <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            {err, letter} <= head_nx;
            overflow      <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_data;
    end

endmodule
